// File: rtl/instr_seq_buffer.sv
// Program buffer that loads a SoftMC instruction program from the host stream and
// replays it in order onto the dispatcher's two same-cycle slots (slot 0 = older).
module instr_seq_buffer #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic                  in_last,
   input  logic                  abort,
   output logic                  en_out0,
   input  logic                  ack0,
   output logic [31:0]           instr_out0,
   output logic                  en_out1,
   input  logic                  ack1,
   output logic [31:0]           instr_out1,
   output logic                  busy,
   output logic                  done,
   output logic [DEPTH_LOG2:0]   prog_len,
   output logic                  overflow,
   output logic                  order_err
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int AW    = DEPTH_LOG2 + 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;

   state_t        state, state_d;
   logic [AW-1:0] wr_cnt, wr_cnt_d;
   logic [AW-1:0] rd_ptr, rd_ptr_d;
   logic [AW-1:0] rd_ptr_inc, rd_next;
   logic          done_d, overflow_d, order_err_d;
   logic          accept, exec, p0, p1;
   logic [31:0]   mem [DEPTH];

   assign exec       = (state == EXEC);
   assign in_ready   = (state != EXEC) && !abort;
   assign accept     = in_valid && in_ready;
   assign busy       = (state != IDLE);
   assign prog_len   = wr_cnt;
   assign rd_ptr_inc = rd_ptr + AW'(1);

   // Slot outputs depend only on registered state, never on the acks.
   assign en_out0    = exec && (rd_ptr < wr_cnt);
   assign en_out1    = exec && (rd_ptr_inc < wr_cnt);
   assign instr_out0 = exec ? mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;
   assign instr_out1 = exec ? mem[rd_ptr_inc[DEPTH_LOG2-1:0]] : '0;

   assign p0      = en_out0 && ack0;
   assign p1      = en_out1 && ack1;
   assign rd_next = rd_ptr + AW'({p0 && p1, p0 && !p1});

   // NOTE: every signal assigned here gets a default first, so no latches are inferred.
   always_comb begin
      state_d     = state;
      wr_cnt_d    = wr_cnt;
      rd_ptr_d    = rd_ptr;
      done_d      = 1'b0;
      overflow_d  = overflow;
      order_err_d = order_err;
      case (state)
         IDLE: begin
            if (accept) begin
               wr_cnt_d    = AW'(1);
               overflow_d  = 1'b0;
               order_err_d = 1'b0;
               state_d     = in_last ? EXEC : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               wr_cnt_d = wr_cnt + AW'(1);
               if (in_last || wr_cnt == LAST_IDX) begin
                  state_d = EXEC;
                  if (!in_last) overflow_d = 1'b1;
               end
            end
         end
         EXEC: begin
            if (p1 && !p0) order_err_d = 1'b1;
            rd_ptr_d = rd_next;
            if (rd_next >= wr_cnt) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               wr_cnt_d = '0;
               rd_ptr_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort beats everything, including a simultaneous final consumption.
      if (abort) begin
         state_d  = IDLE;
         wr_cnt_d = '0;
         rd_ptr_d = '0;
         done_d   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_cnt    <= '0;
         rd_ptr    <= '0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         order_err <= 1'b0;
      end else begin
         state     <= state_d;
         wr_cnt    <= wr_cnt_d;
         rd_ptr    <= rd_ptr_d;
         done      <= done_d;
         overflow  <= overflow_d;
         order_err <= order_err_d;
      end
   end

   // NOTE: the program memory is not reset; entries beyond wr_cnt are never presented.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_cnt[DEPTH_LOG2-1:0]] <= in_instr;
   end

endmodule

// File: doc/instr_seq_buffer.md
# instr_seq_buffer

Program buffer and two-slot instruction feeder sitting directly upstream of the instruction dispatcher. Loads a complete 32-bit SoftMC instruction program from the host-side stream, then replays it in order onto the dispatcher's two same-cycle slots (slot 0 = older, slot 1 = younger) using the dispatcher's en/ack handshake. Signals completion so the host can load the next program.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of program buffer depth in 32-bit words (DEPTH = 2^DEPTH_LOG2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  host instruction word valid.
- in_ready  out  1  buffer accepts a word this cycle.
- in_instr  in  32  host instruction word.
- in_last  in  1  word is the final word of the program.
- abort  in  1  discard current program and return to IDLE.
- en_out0  out  1  slot 0 instruction valid (to dispatcher en_in0).
- ack0  in  1  dispatcher slot 0 ack (en_ack0).
- instr_out0  out  32  slot 0 instruction.
- en_out1  out  1  slot 1 instruction valid (to en_in1).
- ack1  in  1  dispatcher slot 1 ack (en_ack1).
- instr_out1  out  32  slot 1 instruction.
- busy  out  1  high in LOAD or EXEC.
- done  out  1  one-cycle pulse when the last instruction is consumed.
- prog_len  out  DEPTH_LOG2+1  word count of the program being loaded/executed.
- overflow  out  1  sticky: program truncated at DEPTH words.
- order_err  out  1  sticky: slot 1 acked without slot 0.

## Operation
- States: IDLE, LOAD, EXEC.
- IDLE: in_ready=1, wr_cnt=0, rd_ptr=0. Accepted word (in_valid&in_ready) written to mem[0], wr_cnt=1; next state LOAD, or EXEC if in_last.
- LOAD: in_ready=1; each accepted word written to mem[wr_cnt], wr_cnt++. Accepted word with in_last -> EXEC.
- Full: word written at index DEPTH-1 ends loading (-> EXEC) regardless of in_last; if in_last=0, overflow set. in_ready=0 outside IDLE/LOAD.
- EXEC: en_out0 = (rd_ptr < wr_cnt); en_out1 = (rd_ptr+1 < wr_cnt); instr_out0 = mem[rd_ptr], instr_out1 = mem[rd_ptr+1] (async read). en_out*/instr_out* never depend combinationally on ack*.
- Consumption: p0 = en_out0&ack0, p1 = en_out1&ack1. rd_ptr advances by 2 if p0&p1, by 1 if p0&~p1, by 0 otherwise.
- p1&~p0: ordering violation; order_err set, rd_ptr unchanged (instruction re-presented).
- Slot-1 not acked while slot 0 acked (e.g. WAIT>1 blocking the other slot): younger word re-presented on slot 0 next cycle.
- rd_ptr reaching wr_cnt: done=1 for that cycle's successor, state -> IDLE.
- prog_len = wr_cnt; held through EXEC, cleared on entering IDLE.
- abort (any state): -> IDLE next cycle, en_out*=0, no done pulse; overflow/order_err preserved.
- overflow/order_err cleared only by rst or by acceptance of first word of a new program.
- Outside EXEC: en_out0=en_out1=0; instr_out* don't-care.

## Timing
- Reset values: state IDLE, in_ready=1, en_out0=en_out1=0, instr_out*=0, busy=0, done=0, prog_len=0, overflow=0, order_err=0.
- Reset mid-LOAD or mid-EXEC: all outputs to reset values next cycle, program lost.
- Load: 1 word/cycle, no bubbles.
- EXEC entered cycle after the terminating word is accepted; en_out0 high that same cycle.
- Issue throughput: up to 2 words/cycle; en_out/instr_out reflect new rd_ptr one cycle after the ack.
- done asserted exactly one cycle, the cycle after final consumption; busy low that same cycle; in_ready high.
- Odd-length program: final cycle en_out0=1, en_out1=0.
- abort simultaneous with final consumption: abort wins, no done.

## Test plan
- Load 4 words (A,B,C,D; last on D), ack0=ack1=1 constantly -> EXEC cycle 1: slots A/B; cycle 2: C/D; cycle 3: done=1, busy=0, prog_len=0.
- Load 3 words, ack1 tied 0 -> one word per cycle on slot 0 (A, B, C), en_out1 high for first two cycles only, done after C; order_err=0.
- Load A,B,C; cycle 1 ack0=1, ack1=0; cycle 2 ack0=ack1=1 -> slot 0 shows A then B, slot 1 shows B then C; done next cycle.
- ack0=0, ack1=1 while en_out1=1 -> order_err=1, rd_ptr unchanged, same pair re-presented.
- DEPTH_LOG2=2, stream 6 words without in_last -> 4 accepted, overflow=1, prog_len=4, in_ready=0 in EXEC, 4 words issued.
- Assert rst (and separately abort) mid-EXEC after 2 of 6 words -> en_out*=0 next cycle, no done, in_ready=1; new 2-word program then executes normally.
